// File: rtl/vga_text_pkg.sv
// Shared constants for the VGA text console: geometry defaults, control bytes and FSM encodings.
package vga_text_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned ADDR_W = 12;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StClrLine = 2'd1;
  localparam logic [1:0] StClrAll  = 2'd2;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_cursor_ctr.sv
// Cursor position with an incrementally maintained row base, so addr = row*Cols + col needs no
// multiplier.
module vga_cursor_ctr
  import vga_text_pkg::*;
#(
  parameter int unsigned Cols  = COLS,
  parameter int unsigned Rows  = ROWS,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             home_i,
  input  logic             inc_i,
  input  logic             newline_i,
  input  logic             cr_i,
  input  logic             bs_i,
  output logic [6:0]       col_o,
  output logic [4:0]       row_o,
  output logic [AddrW-1:0] addr_o,
  output logic             col_last_o,
  output logic             at_home_o
);

  localparam logic [6:0]       ColLast = 7'(Cols - 1);
  localparam logic [4:0]       RowLast = 5'(Rows - 1);
  localparam logic [AddrW-1:0] ColsA   = AddrW'(Cols);

  logic [6:0]       col_q, col_d;
  logic [4:0]       row_q, row_d;
  logic [AddrW-1:0] base_q, base_d;

  assign col_last_o = (col_q == ColLast);
  assign at_home_o  = (col_q == 7'd0) && (row_q == 5'd0);
  assign col_o      = col_q;
  assign row_o      = row_q;
  assign addr_o     = base_q + AddrW'(col_q);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (home_i) begin
      col_d  = '0;
      row_d  = '0;
      base_d = '0;
    end else if (newline_i || (inc_i && col_last_o)) begin
      col_d = '0;
      if (row_q == RowLast) begin
        row_d  = '0;
        base_d = '0;
      end else begin
        row_d  = row_q + 5'd1;
        base_d = base_q + ColsA;
      end
    end else if (inc_i) begin
      col_d = col_q + 7'd1;
    end else if (cr_i) begin
      col_d = '0;
    end else if (bs_i) begin
      if (col_q != 7'd0) begin
        col_d = col_q - 7'd1;
      end else if (row_q != 5'd0) begin
        col_d  = ColLast;
        row_d  = row_q - 5'd1;
        base_d = base_q - ColsA;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/vga_console_writer.sv
// Byte-stream text console driving the display buffer write port; sweeps blanks on clear and on
// every row advance.
module vga_console_writer
  import vga_text_pkg::*;
#(
  parameter int unsigned Cols  = COLS,
  parameter int unsigned Rows  = ROWS,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ch_valid_i,
  output logic             ch_ready_o,
  input  logic [7:0]       ch_data_i,
  input  logic             clr_req_i,
  output logic             busy_o,
  output logic [6:0]       cur_col_o,
  output logic [4:0]       cur_row_o,
  output logic             disp_wen_o,
  output logic [AddrW-1:0] disp_w_addr_o,
  output logic [7:0]       disp_w_data_o
);

  localparam logic [AddrW-1:0] LastCell = AddrW'(Cols * Rows - 1);
  localparam logic [AddrW-1:0] LastCol  = AddrW'(Cols - 1);

  logic [1:0]       state_q, state_d;
  logic [AddrW-1:0] sweep_q, sweep_d;
  logic             wen_q, wen_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [7:0]       data_q, data_d;

  logic             home, inc, newline, cr, bs;
  logic [AddrW-1:0] cur_addr;
  logic             col_last, at_home;
  logic             accept;

  vga_cursor_ctr #(
    .Cols  (Cols),
    .Rows  (Rows),
    .AddrW (AddrW)
  ) u_cursor (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .home_i     (home),
    .inc_i      (inc),
    .newline_i  (newline),
    .cr_i       (cr),
    .bs_i       (bs),
    .col_o      (cur_col_o),
    .row_o      (cur_row_o),
    .addr_o     (cur_addr),
    .col_last_o (col_last),
    .at_home_o  (at_home)
  );

  assign ch_ready_o = (state_q == StIdle) && !clr_req_i;
  assign accept     = ch_valid_i && ch_ready_o;
  assign busy_o     = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    home    = 1'b0;
    inc     = 1'b0;
    newline = 1'b0;
    cr      = 1'b0;
    bs      = 1'b0;
    // A clear request pre-empts everything, including an in-flight sweep write.
    if (clr_req_i) begin
      state_d = StClrAll;
      sweep_d = '0;
    end else begin
      case (state_q)
        StClrAll: begin
          wen_d  = 1'b1;
          addr_d = sweep_q;
          data_d = CH_SPACE;
          if (sweep_q == LastCell) begin
            state_d = StIdle;
            sweep_d = '0;
            home    = 1'b1;
          end else begin
            sweep_d = sweep_q + AddrW'(1);
          end
        end
        StClrLine: begin
          // Cursor sits at column 0 of the new row, so cur_addr is the row base.
          wen_d  = 1'b1;
          addr_d = cur_addr + sweep_q;
          data_d = CH_SPACE;
          if (sweep_q == LastCol) begin
            state_d = StIdle;
            sweep_d = '0;
          end else begin
            sweep_d = sweep_q + AddrW'(1);
          end
        end
        StIdle: begin
          if (accept) begin
            if (is_printable(ch_data_i)) begin
              wen_d  = 1'b1;
              addr_d = cur_addr;
              data_d = ch_data_i;
              inc    = 1'b1;
              if (col_last) state_d = StClrLine;
            end else begin
              case (ch_data_i)
                CH_LF: begin
                  newline = 1'b1;
                  state_d = StClrLine;
                end
                CH_CR: cr = 1'b1;
                CH_BS: begin
                  if (!at_home) begin
                    wen_d  = 1'b1;
                    addr_d = cur_addr - AddrW'(1);
                    data_d = CH_SPACE;
                    bs     = 1'b1;
                  end
                end
                CH_FF: begin
                  state_d = StClrAll;
                  sweep_d = '0;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          state_d = StClrAll;
          sweep_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClrAll;
      sweep_q <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign disp_wen_o    = wen_q;
  assign disp_w_addr_o = addr_q;
  assign disp_w_data_o = data_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer: clears, printing, control bytes, wrap, clear/reset preemption.
module tb_vga_console_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        clr_req = 1'b0;
  logic        ch_ready;
  logic        busy;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        disp_wen;
  logic [11:0] disp_w_addr;
  logic [7:0]  disp_w_data;

  int n_cmp = 0;
  int n_bad = 0;

  vga_console_writer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ch_valid_i    (ch_valid),
    .ch_ready_o    (ch_ready),
    .ch_data_i     (ch_data),
    .clr_req_i     (clr_req),
    .busy_o        (busy),
    .cur_col_o     (cur_col),
    .cur_row_o     (cur_row),
    .disp_wen_o    (disp_wen),
    .disp_w_addr_o (disp_w_addr),
    .disp_w_data_o (disp_w_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input int addr, input logic [7:0] d);
    check(tag, {11'd0, disp_wen, disp_w_addr, disp_w_data}, {11'd0, 1'b1, 12'(addr), d});
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    check(tag, {20'd0, cur_row, cur_col}, {20'd0, 5'(row), 7'(col)});
  endtask

  task automatic expect_writes(input string tag, input int n, input int base,
                               input logic [7:0] d, input bit chk_ready);
    for (int i = 0; i < n; i++) begin
      check_write(tag, base + i, d);
      if (chk_ready && i < n - 1) check({tag, "_ready"}, 32'(ch_ready), 32'd0);
      step();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (!ch_ready && guard < 5000) begin
      step();
      guard++;
    end
    if (!ch_ready) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: observed ch_ready=0 expected ch_ready=1 for byte 0x%0h", b);
    end
    ch_valid = 1'b1;
    ch_data  = b;
    step();
    ch_valid = 1'b0;
  endtask

  task automatic wait_write(input string tag, input int bound);
    int guard = 0;
    while (!disp_wen && guard < bound) begin
      step();
      guard++;
    end
    if (!disp_wen) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed no write expected a write within %0d cycles", tag, bound);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    // Reset state
    check("rst_wen", 32'(disp_wen), 32'd0);
    check("rst_addr", 32'(disp_w_addr), 32'd0);
    check("rst_data", 32'(disp_w_data), 32'd0);
    check_cursor("rst_cursor", 0, 0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(ch_ready), 32'd0);

    // 1: power-on clear
    rst_n = 1'b1;
    step();
    expect_writes("clr_all", 2400, 0, 8'h20, 1'b1);
    check("clr_all_wen_off", 32'(disp_wen), 32'd0);
    check("clr_all_busy", 32'(busy), 32'd0);
    check_cursor("clr_all_cursor", 0, 0);

    // 2: single printable
    send_byte(8'h41);
    check_write("print_A", 0, 8'h41);
    check_cursor("print_A_cursor", 0, 1);
    step();
    check("wen_pulse", 32'(disp_wen), 32'd0);

    // 3: CR then a full row, auto-wrap into a line clear
    send_byte(8'h0D);
    check("cr_nowrite", 32'(disp_wen), 32'd0);
    check_cursor("cr_cursor", 0, 0);
    for (int i = 0; i < 80; i++) begin
      send_byte(8'h78);
      check_write("row_fill", i, 8'h78);
    end
    step();
    expect_writes("line_clr", 80, 80, 8'h20, 1'b0);
    check_cursor("line_clr_cursor", 1, 0);
    check("line_clr_busy", 32'(busy), 32'd0);

    send_byte(8'h01);
    check("other_nowrite", 32'(disp_wen), 32'd0);
    check_cursor("other_cursor", 1, 0);

    // 5: backspace across a row boundary, and at home
    send_byte(8'h08);
    check_write("bs_wrap", 79, 8'h20);
    check_cursor("bs_wrap_cursor", 0, 79);
    send_byte(8'h0D);
    check_cursor("cr2_cursor", 0, 0);
    send_byte(8'h08);
    check("bs_home_nowrite", 32'(disp_wen), 32'd0);
    check_cursor("bs_home_cursor", 0, 0);

    // 4: walk to the last row, then LF wraps to row 0 and clears it
    for (int i = 0; i < 29; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h61);
    check_write("row29_print", 29 * 80 + 4, 8'h61);
    check_cursor("row29_cursor", 29, 5);
    send_byte(8'h0A);
    check("lf_nowrite", 32'(disp_wen), 32'd0);
    check_cursor("wrap_cursor", 0, 0);
    step();
    expect_writes("wrap_clr", 80, 0, 8'h20, 1'b0);

    // 6a: clear request during a line sweep, then reset mid-sweep
    send_byte(8'h0A);
    step();
    expect_writes("line_pre", 2, 80, 8'h20, 1'b0);
    clr_req  = 1'b1;
    ch_valid = 1'b1;
    ch_data  = 8'h5A;
    #1;
    check("clr_sweep_ready", 32'(ch_ready), 32'd0);
    step();
    clr_req  = 1'b0;
    ch_valid = 1'b0;
    wait_write("clr_restart_wait", 4);
    expect_writes("clr_restart", 10, 0, 8'h20, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wen", 32'(disp_wen), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    expect_writes("rst_restart", 2400, 0, 8'h20, 1'b0);
    check_cursor("rst_restart_cursor", 0, 0);
    check("rst_restart_busy", 32'(busy), 32'd0);

    // 6b: clear request wins over a simultaneous byte in idle
    send_byte(8'h42);
    check_write("print_B", 0, 8'h42);
    step();
    clr_req  = 1'b1;
    ch_valid = 1'b1;
    ch_data  = 8'h5A;
    #1;
    check("clr_wins_ready", 32'(ch_ready), 32'd0);
    step();
    clr_req  = 1'b0;
    ch_valid = 1'b0;
    check("clr_wins_nowrite", 32'(disp_wen), 32'd0);
    check("clr_wins_busy", 32'(busy), 32'd1);
    check_cursor("clr_wins_cursor_hold", 0, 1);
    wait_write("clr_idle_wait", 4);
    expect_writes("clr_idle", 2400, 0, 8'h20, 1'b0);
    check_cursor("clr_idle_cursor", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
